sobel_edge: RTL
===============

// Module: sobel_edge
// PURPOSE
//  Sobel edge detector on the AXI4-Stream video path, directly downstream of the
//  RGB-to-grey stage. Consumes grey pixels replicated as {g,g,g}. Emits a binary
//  edge map, also as {e,e,e}, with e = 8'hFF (edge) or 8'h00.
//  Uses two line buffers and a 3x3 window. Frame size and framing are preserved.
// PARAMETERS
//  IMG_WIDTH  640  max pixels per line (line-buffer depth)
//  COL_W      10   column counter width, >= clog2(IMG_WIDTH)
//  ROW_W      10   row counter width
//  THRESHOLD  100  edge when |Gx|+|Gy| > THRESHOLD (12-bit unsigned compare)
// PORTS
//  aclk           in   1   clock, all logic on rising edge
//  aresetn        in   1   asynchronous active-low reset
//  s_axis_tvalid  in   1   input pixel valid
//  s_axis_tdata   in   24  grey pixel; only [7:0] used
//  s_axis_tready  out  1   input accept
//  s_axis_tuser   in   1   start of frame (first pixel)
//  s_axis_tlast   in   1   end of line
//  m_axis_tvalid  out  1   output valid
//  m_axis_tdata   out  24  {e,e,e}
//  m_axis_tready  in   1   downstream accept
//  m_axis_tuser   out  1   SOF, aligned with its pixel
//  m_axis_tlast   out  1   EOL, aligned with its pixel
// BEHAVIOUR
//  - Reset (async, aresetn=0): m_axis_tvalid/tdata/tuser/tlast=0; col, row, window, stage valids=0.
//    Line-buffer RAM is not reset.
//  - Pipeline enable: en = !m_axis_tvalid || m_axis_tready; s_axis_tready = en.
//    Accept = s_axis_tvalid && en. When en=0 every stage holds; no drop, no duplicate.
//  - Latency: 2 cycles, accept -> m_axis_tvalid, while unstalled. Throughput 1 pixel/clk. Bubbles propagate.
//  - Counters, updated on accept:
//    tuser beat: col=0, row=0 (forces a new frame).
//    Beat with tlast: col=0, row=row+1 (row saturates at max).
//    Otherwise: col=col+1, saturating at IMG_WIDTH-1.
//    The pixel's own position (c,r) is the value before the update.
//  - Stage 1, on accept at (c,r): a=lb1[c], b=lb0[c], p=pixel.
//    Shift column {a,b,p} into the 3x3 window (oldest column drops).
//    Write lb1[c]<=b, lb0[c]<=p. Register border flag, tuser, tlast, valid.
//    Beats with col saturated do not write the line buffers.
//  - Border flag = (r<2) || (c<2).
//  - Stage 2: window w[row][col], col 2 newest, row 2 newest.
//    Gx = (w02+2w12+w22)-(w00+2w10+w20)
//    Gy = (w20+2w21+w22)-(w00+2w01+w02)
//    Gx, Gy: 11-bit signed. mag = |Gx|+|Gy|: 12-bit unsigned, max 2040.
//    e = (!border && mag>THRESHOLD) ? 8'hFF : 8'h00.
//  - Alignment: output at (c,r) is the Sobel result centred on input pixel (c-1,r-1).
//    Output count equals input count. No flush at end of frame.
//  - tuser and tlast travel with their pixel; output framing is identical to input.
//  - Short line (tlast before IMG_WIDTH): next row starts at col 0. Unused line-buffer
//    entries are stale and never read within that width.
//  - tuser and tlast on the same beat: treat as a 1-pixel line. Result: col=0, row=1.
//  - Reset mid-frame: outputs clear immediately. Following beats count from (0,0)
//    until the next tuser, so the first 2 rows and 2 cols are forced to 0.
// TESTING
//  1 Reset: aresetn=0 mid-stream, with m_axis_tvalid=1 -> m_axis_tvalid=0 and m_axis_tdata=0
//    immediately, before the next aclk edge.
//  2 Uniform: 8x4 frame, all 0x80 -> 32 outputs, all 24'h000000. tuser on beat 0 only;
//    tlast on beats 7,15,23,31.
//  3 Vertical step: 8x6 frame, cols 0-3=0x00, cols 4-7=0xFF -> 24'hFFFFFF at cols 4,5 of rows 2-5
//    (|Gx|=1020). All other outputs 0.
//  4 Backpressure: case 3 with m_axis_tready pseudo-random (~50%) -> bit-identical output sequence.
//    s_axis_tready=0 whenever m_axis_tvalid=1 and m_axis_tready=0.
//  5 Threshold: rows 0-2=0x00, rows 3-5=0x19 -> mag=100, all outputs 0.
//    Same with 0x1A -> mag=104, 24'hFFFFFF at rows 3,4 for cols>=2.
//  6 Back-to-back: two 8x6 frames of case 3, no gap -> frame 2 rows 0-1 all 0.
//    m_axis_tuser on beat 48; pattern otherwise repeats.

Source files
------------

// File: rtl/sobel_edge_if.sv
// Pixel stream bundle (AXI4-Stream video subset): valid/ready handshake with
// 24-bit data, start-of-frame (tuser) and end-of-line (tlast) markers.
interface sobel_edge_if;
  logic        tvalid;
  logic [23:0] tdata;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/sobel_edge.sv
// 3x3 Sobel edge detector on a grey {g,g,g} stream, emitting {e,e,e} with e=FF on edges.
// Latency 2 cycles from accept; whole pipeline stalls while the output is held by backpressure.
module sobel_edge #(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = 10,
  parameter int ROW_W     = 10,
  parameter int THRESHOLD = 100
) (
  input  logic         aclk,
  input  logic         aresetn,
  sobel_edge_if.slave  s_axis,
  sobel_edge_if.master m_axis
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;
  localparam logic [11:0]      THR     = 12'(THRESHOLD);

  // ---------------------------------------------------------------- handshake
  logic        en;
  logic        acc;
  logic        out_vld;
  logic [23:0] out_dat;
  logic        out_user;
  logic        out_last;

  assign en            = !out_vld || m_axis.tready;
  assign acc           = s_axis.tvalid && en;
  assign s_axis.tready = en;

  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;

  logic [7:0] pix;
  logic       unused_hi;
  assign pix       = s_axis.tdata[7:0];
  assign unused_hi = ^s_axis.tdata[23:8];

  // ---------------------------------------------------------------- position
  // A tuser beat is itself pixel (0,0) of the new frame, so the stored
  // counters are overridden before use rather than after.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             sat;
  logic [COL_W-1:0] c;
  logic [ROW_W-1:0] r;
  logic             sat_eff;

  assign c       = s_axis.tuser ? '0   : col;
  assign r       = s_axis.tuser ? '0   : row;
  assign sat_eff = s_axis.tuser ? 1'b0 : sat;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      col <= '0;
      row <= '0;
      sat <= 1'b0;
    end else if (acc) begin
      if (s_axis.tlast) begin
        col <= '0;
        row <= (r == ROW_MAX) ? r : r + 1'b1;
        sat <= 1'b0;
      end else if (c == COL_MAX) begin
        col <= c;
        row <= r;
        sat <= 1'b1;
      end else begin
        col <= c + 1'b1;
        row <= r;
        sat <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- line buffers
  logic [7:0] lb0 [0:IMG_WIDTH-1];
  logic [7:0] lb1 [0:IMG_WIDTH-1];
  logic [7:0] up2;
  logic [7:0] up1;

  assign up2 = lb1[c];
  assign up1 = lb0[c];

  always_ff @(posedge aclk) begin
    if (acc && !sat_eff) begin
      lb1[c] <= up1;
      lb0[c] <= pix;
    end
  end

  // ---------------------------------------------------------------- stage 1: window
  logic [7:0] win [0:2][0:2];
  logic       s1_vld;
  logic       s1_border;
  logic       s1_user;
  logic       s1_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_vld    <= 1'b0;
      s1_border <= 1'b0;
      s1_user   <= 1'b0;
      s1_last   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= 8'h00;
        end
      end
    end else if (en) begin
      s1_vld <= acc;
      if (acc) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 2; j++) begin
            win[i][j] <= win[i][j+1];
          end
        end
        win[0][2] <= up2;
        win[1][2] <= up1;
        win[2][2] <= pix;
        s1_border <= (r < ROW_W'(2)) || (c < COL_W'(2));
        s1_user   <= s_axis.tuser;
        s1_last   <= s_axis.tlast;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2: gradient
  function automatic logic [10:0] tap3(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] z);
    tap3 = {3'b000, x} + {2'b00, y, 1'b0} + {3'b000, z};
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    abs11 = v[10] ? 11'(-v) : 11'(v);
  endfunction

  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic        [11:0] mag;
  logic               is_edge;

  assign gx      = $signed(tap3(win[0][2], win[1][2], win[2][2]))
                 - $signed(tap3(win[0][0], win[1][0], win[2][0]));
  assign gy      = $signed(tap3(win[2][0], win[2][1], win[2][2]))
                 - $signed(tap3(win[0][0], win[0][1], win[0][2]));
  assign mag     = {1'b0, abs11(gx)} + {1'b0, abs11(gy)};
  assign is_edge = !s1_border && (mag > THR);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld  <= 1'b0;
      out_dat  <= 24'h000000;
      out_user <= 1'b0;
      out_last <= 1'b0;
    end else if (en) begin
      out_vld  <= s1_vld;
      out_dat  <= (s1_vld && is_edge) ? 24'hFFFFFF : 24'h000000;
      out_user <= s1_vld && s1_user;
      out_last <= s1_vld && s1_last;
    end
  end

endmodule
